// File: rtl/req_ack_tx_arbiter.sv
// Round-robin arbiter that holds one granted 64-bit packet until the req/ack
// link sender is available, with a sent-packet counter and a sticky stall flag.
module req_ack_tx_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int TO_WIDTH  = 16,
  parameter int CNT_WIDTH = 16,
  localparam int IDW      = $clog2(NUM_SRC)
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_SRC-1:0]      src_enable,
  input  logic [NUM_SRC-1:0]      src_valid,
  input  logic [64*NUM_SRC-1:0]   src_data,
  output logic [NUM_SRC-1:0]      src_ready,
  input  logic [TO_WIDTH-1:0]     timeout_cfg,
  output logic                    tx_valid,
  output logic [63:0]             tx_din,
  input  logic                    tx_available,
  output logic [IDW-1:0]          grant_id,
  output logic [CNT_WIDTH-1:0]    tx_count,
  output logic                    err_timeout,
  input  logic                    err_clear
);

  typedef enum logic {IDLE, SEND} state_t;

  localparam logic [IDW:0] NUM_SRC_W = (IDW+1)'(NUM_SRC);

  state_t               state;
  logic [IDW-1:0]       last;
  logic [TO_WIDTH-1:0]  stall;
  logic [TO_WIDTH-1:0]  stall_next;
  logic [NUM_SRC-1:0]   eligible;
  logic [IDW:0]         cand;
  logic [IDW-1:0]       pick;
  logic                 pick_found;
  logic                 set_err;

  // Rotating search starting just after the last granted source.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    eligible   = src_valid & src_enable;
    pick       = '0;
    pick_found = 1'b0;
    cand       = '0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      cand = {1'b0, last} + (IDW+1)'(k);
      if (cand >= NUM_SRC_W) cand = cand - NUM_SRC_W;
      if (!pick_found && eligible[cand[IDW-1:0]]) begin
        pick_found = 1'b1;
        pick       = cand[IDW-1:0];
      end
    end
    src_ready = '0;
    if (rstn && state == IDLE && pick_found) src_ready[pick] = 1'b1;
  end

  always_comb begin
    stall_next = (stall == '1) ? stall : stall + TO_WIDTH'(1);
    set_err    = (state == SEND) && !tx_available &&
                 (timeout_cfg != '0) && (stall_next == timeout_cfg);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state       <= IDLE;
      tx_valid    <= 1'b0;
      tx_din      <= '0;
      grant_id    <= '0;
      last        <= IDW'(NUM_SRC - 1);
      tx_count    <= '0;
      err_timeout <= 1'b0;
      stall       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            tx_din   <= src_data[64*pick +: 64];
            grant_id <= pick;
            last     <= pick;
            tx_valid <= 1'b1;
            stall    <= '0;
            state    <= SEND;
          end
        end
        SEND: begin
          if (tx_available) begin
            tx_valid <= 1'b0;
            tx_count <= tx_count + CNT_WIDTH'(1);
            stall    <= '0;
            state    <= IDLE;
          end else begin
            stall <= stall_next;
          end
        end
        default: state <= IDLE;
      endcase

      // A new stall event beats a simultaneous clear.
      if (set_err)        err_timeout <= 1'b1;
      else if (err_clear) err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_req_ack_tx_arbiter.sv
// Scoreboard bench for req_ack_tx_arbiter: a round-robin reference model pushes
// expected packets at accept time, a monitor pops them at each link transfer.
module tb_req_ack_tx_arbiter;

  localparam int NS = 4;
  localparam int CW = 8;

  logic            clk = 1'b0;
  logic            rstn = 1'b0;
  logic [NS-1:0]   src_enable = '0;
  logic [NS-1:0]   src_valid = '0;
  logic [64*NS-1:0] src_data = '0;
  logic [NS-1:0]   src_ready;
  logic [15:0]     timeout_cfg = '0;
  logic            tx_valid;
  logic [63:0]     tx_din;
  logic            tx_available = 1'b0;
  logic [1:0]      grant_id;
  logic [CW-1:0]   tx_count;
  logic            err_timeout;
  logic            err_clear = 1'b0;

  req_ack_tx_arbiter #(.NUM_SRC(NS), .TO_WIDTH(16), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rstn(rstn), .src_enable(src_enable), .src_valid(src_valid),
    .src_data(src_data), .src_ready(src_ready), .timeout_cfg(timeout_cfg),
    .tx_valid(tx_valid), .tx_din(tx_din), .tx_available(tx_available),
    .grant_id(grant_id), .tx_count(tx_count), .err_timeout(err_timeout),
    .err_clear(err_clear)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [63:0] data;
  } exp_t;

  exp_t        sb[$];
  int          seen[$];
  int          n_checks = 0;
  int          n_pass = 0;
  bit          m_busy = 1'b0;
  int          m_last = NS - 1;
  logic [CW-1:0] m_count = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // First eligible source scanning last+1, last+2, ... modulo NS; -1 if none.
  function automatic int rr_pick(input logic [NS-1:0] elig, input int last);
    for (int k = 1; k <= NS; k++) begin
      if (elig[(last + k) % NS]) return (last + k) % NS;
    end
    return -1;
  endfunction

  // One clock of stimulus plus model update; inputs change 1 ns after the edge.
  task automatic cycle(input logic [NS-1:0] v, input logic [NS-1:0] en,
                       input logic av, input logic ec, input bit rnd);
    int p;
    logic [NS-1:0] exp_ready;
    @(posedge clk); #1;
    src_valid = v; src_enable = en; tx_available = av; err_clear = ec;
    if (rnd) for (int i = 0; i < NS; i++) src_data[64*i +: 64] = {$urandom, $urandom};
    #1;
    exp_ready = '0;
    p = -1;
    if (!m_busy) begin
      p = rr_pick(v & en, m_last);
      if (p >= 0) begin
        exp_ready[p] = 1'b1;
        sb.push_back('{id: p, data: src_data[64*p +: 64]});
        m_last = p;
      end
    end
    check("src_ready", {60'd0, src_ready}, {60'd0, exp_ready});
    check("tx_valid", {63'd0, tx_valid}, {63'd0, m_busy});
    if (m_busy) begin
      if (av) m_busy = 1'b0;
    end else if (p >= 0) begin
      m_busy = 1'b1;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rstn = 1'b0; src_valid = '1; src_enable = '1; tx_available = 1'b0; err_clear = 1'b0;
    @(posedge clk); #1;
    check("rst_src_ready", {60'd0, src_ready}, 64'd0);
    check("rst_tx_valid", {63'd0, tx_valid}, 64'd0);
    check("rst_tx_count", {56'd0, tx_count}, 64'd0);
    check("rst_err", {63'd0, err_timeout}, 64'd0);
    check("rst_tx_din", tx_din, 64'd0);
    rstn = 1'b1; src_valid = '0;
    m_busy = 1'b0; m_last = NS - 1; m_count = '0;
    sb.delete(); seen.delete();
  endtask

  // Monitor: a transfer happens on any cycle with tx_valid & tx_available.
  always @(negedge clk) begin
    if (rstn && tx_valid && tx_available) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 64'd0, 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("tx_din", tx_din, e.data);
        check("grant_id", {62'd0, grant_id}, 64'(e.id));
      end
      check("tx_count", {56'd0, tx_count}, {56'd0, m_count});
      m_count = m_count + 1'b1;
      seen.push_back(int'(grant_id));
    end
  end

  initial begin
    int exp_order[6];
    exp_order = '{0, 1, 2, 3, 0, 1};

    // Single packet from source 0, latency and data.
    do_reset();
    src_data[63:0] = 64'h1111_2222_3333_4444;
    cycle(4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0);
    check("t1_ready", {60'd0, src_ready}, 64'h1);
    cycle(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
    check("t1_tx_valid", {63'd0, tx_valid}, 64'd1);
    check("t1_tx_din", tx_din, 64'h1111_2222_3333_4444);
    cycle(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b0);
    check("t1_count", {56'd0, tx_count}, 64'd1);
    check("t1_grant", {62'd0, grant_id}, 64'd0);

    // Full contention: strict rotation 0,1,2,3,0,1.
    do_reset();
    for (int i = 0; i < 12; i++) cycle(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cycle(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1);
    check("t2_grants", 64'(seen.size()), 64'd6);
    for (int i = 0; i < 6 && i < seen.size(); i++)
      check("t2_order", 64'(seen[i]), 64'(exp_order[i]));

    // Masked sources: only 1 and 3 alternate.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(4'b1111, 4'b1010, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) cycle(4'b0000, 4'b1010, 1'b1, 1'b0, 1'b1);
    check("t3_grants", 64'(seen.size()), 64'd4);
    for (int i = 0; i < seen.size(); i++)
      check("t3_order", 64'(seen[i]), (i % 2 == 0) ? 64'd1 : 64'd3);

    // Stall timeout: flag on 5th stall cycle, packet still delivered, sticky.
    do_reset();
    timeout_cfg = 16'd5;
    cycle(4'b0001, 4'b1111, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) cycle(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1);
    check("t4_err_before", {63'd0, err_timeout}, 64'd0);
    cycle(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1);
    check("t4_err_set", {63'd0, err_timeout}, 64'd1);
    check("t4_valid_held", {63'd0, tx_valid}, 64'd1);
    cycle(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1);
    check("t4_count", {56'd0, tx_count}, 64'd1);
    cycle(4'b0000, 4'b1111, 1'b1, 1'b1, 1'b1);
    check("t4_err_sticky", {63'd0, err_timeout}, 64'd1);
    cycle(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1);
    check("t4_err_cleared", {63'd0, err_timeout}, 64'd0);

    // Counter wrap: 2^CW transfers bring tx_count back to zero.
    do_reset();
    timeout_cfg = 16'd0;
    for (int i = 0; i < 2 * (1 << CW); i++) cycle(4'b0001, 4'b1111, 1'b1, 1'b0, 1'b1);
    cycle(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1);
    check("t5_wrap", {56'd0, tx_count}, 64'd0);

    // Reset while a stalled packet is held in SEND.
    do_reset();
    timeout_cfg = 16'd5;
    cycle(4'b1100, 4'b1111, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) cycle(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1);
    check("t6_err_pre", {63'd0, err_timeout}, 64'd1);
    do_reset();
    cycle(4'b1111, 4'b1111, 1'b1, 1'b0, 1'b1);
    check("t6_first_grant", {60'd0, src_ready}, 64'h1);

    // Randomized traffic against the model, timeout disabled.
    timeout_cfg = 16'd0;
    for (int i = 0; i < 3000; i++)
      cycle(4'($urandom), 4'($urandom), ($urandom_range(0, 3) != 0), 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cycle(4'b0000, 4'b1111, 1'b1, 1'b0, 1'b1);
    check("rand_drained", 64'(sb.size()), 64'd0);
    check("rand_no_err", {63'd0, err_timeout}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
